// File: rtl/demux1to3_32bit_stream.sv
// demux1to3_32bit_stream: registered 1-to-3 word demultiplexer with per-channel valid/ready holding registers.
// Optional per-channel handshake counters are enabled by defining DEMUX3_STATS_EN.
module demux1to3_32bit_stream #(
    parameter int WIDTH  = 32,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out1_valid,
    output logic              out2_valid,
    output logic              out3_valid,
    input  logic              out1_ready,
    input  logic              out2_ready,
    input  logic              out3_ready,
    output logic [WIDTH-1:0]  out1_data,
    output logic [WIDTH-1:0]  out2_data,
    output logic [WIDTH-1:0]  out3_data,
`ifdef DEMUX3_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       cnt1,
    output logic [15:0]       cnt2,
    output logic [15:0]       cnt3,
`endif
    output logic [DROP_W-1:0] drop_cnt
);
    logic [2:0]        vld_q, vld_d, rdy, free, hit;
    logic [WIDTH-1:0]  data_q [3];
    logic [WIDTH-1:0]  data_d [3];
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              accept;

    assign rdy        = {out3_ready, out2_ready, out1_ready};
    assign free       = ~vld_q | rdy;
    assign out1_valid = vld_q[0];
    assign out2_valid = vld_q[1];
    assign out3_valid = vld_q[2];
    assign out1_data  = data_q[0];
    assign out2_data  = data_q[1];
    assign out3_data  = data_q[2];
    assign drop_cnt   = drop_q;

    // Ready depends only on the selected channel having room; discard is always ready, nothing during reset.
    always_comb begin
        in_ready = rst_n && (in_sel == 2'b00 ? free[0] :
                             in_sel == 2'b01 ? free[1] :
                             in_sel == 2'b10 ? free[2] : 1'b1);
        accept   = in_valid && in_ready;
        for (int i = 0; i < 3; i++) begin
            hit[i]    = accept && (in_sel == 2'(i));
            vld_d[i]  = hit[i] || (vld_q[i] && !rdy[i]);
            data_d[i] = hit[i] ? in_data : data_q[i];
        end
        drop_d = (accept && in_sel == 2'b11 && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    end

    // Channel holding registers and saturating discard counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            drop_q <= '0;
            for (int i = 0; i < 3; i++) data_q[i] <= '0;
        end else begin
            vld_q  <= vld_d;
            drop_q <= drop_d;
            for (int i = 0; i < 3; i++) data_q[i] <= data_d[i];
        end
    end

`ifdef DEMUX3_STATS_EN
    logic [15:0] cnt_q [3];
    logic [15:0] cnt_d [3];

    assign cnt1 = cnt_q[0];
    assign cnt2 = cnt_q[1];
    assign cnt3 = cnt_q[2];

    // Count completed output handshakes; a clear wins over a same-cycle increment.
    always_comb begin
        for (int i = 0; i < 3; i++) cnt_d[i] = stat_clr ? 16'd0 : cnt_q[i] + 16'(vld_q[i] && rdy[i]);
    end

    // Handshake counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`endif
endmodule

// File: tb/tb_demux1to3_32bit_stream.sv
// tb_demux1to3_32bit_stream: directed self-checking bench for demux1to3_32bit_stream.
module tb_demux1to3_32bit_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_sel = 2'b00;
    logic [31:0] in_data = 32'd0;
    logic        out1_valid, out2_valid, out3_valid;
    logic        out1_ready = 1'b0, out2_ready = 1'b0, out3_ready = 1'b0;
    logic [31:0] out1_data, out2_data, out3_data;
    logic [7:0]  drop_cnt;
`ifdef DEMUX3_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] cnt1, cnt2, cnt3;
`endif
    int checks = 0;
    int errors = 0;

    demux1to3_32bit_stream dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data),
        .out1_valid(out1_valid), .out2_valid(out2_valid), .out3_valid(out3_valid),
        .out1_ready(out1_ready), .out2_ready(out2_ready), .out3_ready(out3_ready),
        .out1_data(out1_data), .out2_data(out2_data), .out3_data(out3_data),
`ifdef DEMUX3_STATS_EN
        .stat_clr(stat_clr), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
`endif
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
        @(negedge clk);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_valids", 32'({out3_valid, out2_valid, out1_valid}), 32'd0);
        chk("reset_data1", out1_data, 32'd0);
        chk("reset_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 2'b00, 32'h00000002);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        edge_settle();
        chk("t1_out1_valid", 32'(out1_valid), 32'd1);
        chk("t1_out1_data", out1_data, 32'h00000002);
        chk("t1_others", 32'({out3_valid, out2_valid}), 32'd0);
        drive(1'b1, 2'b01, 32'hFFFFFFFA);
        chk("t2_in_ready", 32'(in_ready), 32'd1);
        edge_settle();
        chk("t2_out2_valid", 32'(out2_valid), 32'd1);
        chk("t2_out2_data", out2_data, 32'hFFFFFFFA);
        chk("t2_out1_drained", 32'(out1_valid), 32'd0);
        drive(1'b1, 2'b01, 32'h55AAAAAA);
        chk("t3_in_ready_stall", 32'(in_ready), 32'd0);
        edge_settle();
        chk("t3_out2_hold_valid", 32'(out2_valid), 32'd1);
        chk("t3_out2_hold_data", out2_data, 32'hFFFFFFFA);
        drive(1'b1, 2'b10, 32'h55AAAAAA);
        chk("t4_in_ready_ch3", 32'(in_ready), 32'd1);
        edge_settle();
        chk("t4_out3_valid", 32'(out3_valid), 32'd1);
        chk("t4_out3_data", out3_data, 32'h55AAAAAA);
        chk("t4_out2_still", out2_data, 32'hFFFFFFFA);
        drive(1'b1, 2'b01, 32'h55AAAAAA);
        out2_ready = 1'b1;
        out3_ready = 1'b1;
        #1;
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        edge_settle();
        chk("t5_out2_valid", 32'(out2_valid), 32'd1);
        chk("t5_out2_data", out2_data, 32'h55AAAAAA);
        chk("t5_out3_drained", 32'(out3_valid), 32'd0);
        drive(1'b0, 2'b01, 32'h12345678);
        edge_settle();
        chk("t6_out2_drained", 32'(out2_valid), 32'd0);
        chk("t6_out2_data_kept", out2_data, 32'h55AAAAAA);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 2'b00, 32'(k));
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            edge_settle();
            chk("b2b_out1_valid", 32'(out1_valid), 32'd1);
            chk("b2b_out1_data", out1_data, 32'(k));
        end
        for (int k = 1; k <= 260; k++) begin
            drive(1'b1, 2'b11, 32'hDEAD0000 + 32'(k));
            chk("drop_in_ready", 32'(in_ready), 32'd1);
            edge_settle();
            chk("drop_cnt", 32'(drop_cnt), (k > 255) ? 32'd255 : 32'(k));
        end
        chk("drop_no_valid", 32'({out3_valid, out2_valid, out1_valid}), 32'd0);
        chk("drop_out1_data", out1_data, 32'd8);
        drive(1'b0, 2'b00, 32'hCAFEF00D);
        edge_settle();
        chk("idle_no_load", 32'(out1_valid), 32'd0);
        chk("idle_drop", 32'(drop_cnt), 32'd255);
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        out3_ready = 1'b0;
        drive(1'b1, 2'b00, 32'hA1);
        edge_settle();
        drive(1'b1, 2'b01, 32'hA2);
        edge_settle();
        drive(1'b1, 2'b10, 32'hA3);
        edge_settle();
        drive(1'b0, 2'b00, 32'h0);
        chk("full_valids", 32'({out3_valid, out2_valid, out1_valid}), 32'd7);
        chk("full_data1", out1_data, 32'hA1);
        chk("full_data3", out3_data, 32'hA3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valids", 32'({out3_valid, out2_valid, out1_valid}), 32'd0);
        chk("async_data2", out2_data, 32'd0);
        chk("async_drop", 32'(drop_cnt), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DEMUX3_STATS_EN
        out1_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'b00, 32'(k));
            edge_settle();
        end
        drive(1'b0, 2'b00, 32'h0);
        edge_settle();
        chk("stats_cnt1", 32'(cnt1), 32'd3);
        chk("stats_cnt2", 32'(cnt2), 32'd0);
        @(negedge clk);
        stat_clr = 1'b1;
        edge_settle();
        stat_clr = 1'b0;
        chk("stats_clr", 32'(cnt1), 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
